// File: rtl/bomb_fuse_scheduler.sv
// Bomb-fuse scheduler: allocates a fixed pool of bomb slots and counts down
// their fuses on the one-second tick. Chain-reaction hits can force early
// expiry. Expired bombs are reported one per clock, lowest slot index first.

// Per-slot bomb state: FREE -> ARMED -> PENDING -> FREE
module bomb_fuse_slot #(
   parameter int FUSE_SEC = 3,
   parameter int COORD_W  = 4
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               place_en,
   input  logic [COORD_W-1:0] place_col,
   input  logic [COORD_W-1:0] place_row,
   input  logic               dec_en,
   input  logic               det_req,
   input  logic [COORD_W-1:0] det_col,
   input  logic [COORD_W-1:0] det_row,
   input  logic               report_en,
   output logic               armed,
   output logic               pending,
   output logic               active_d,
   output logic [COORD_W-1:0] col,
   output logic [COORD_W-1:0] row
);

   typedef enum logic [1:0] {
      S_FREE    = 2'd0,
      S_ARMED   = 2'd1,
      S_PENDING = 2'd2
   } slot_state_e;

   slot_state_e        state_q, state_d;
   logic [2:0]         fuse_q, fuse_d;
   logic [COORD_W-1:0] col_q, col_d;
   logic [COORD_W-1:0] row_q, row_d;

   // Next-state: a hit takes precedence over the tick, so a hit and an
   // expiry on the same edge collapse into a single PENDING.
   always_comb begin
      state_d = state_q;
      fuse_d  = fuse_q;
      col_d   = col_q;
      row_d   = row_q;
      case (state_q)
         S_FREE: begin
            if (place_en) begin
               state_d = S_ARMED;
               fuse_d  = 3'(FUSE_SEC);
               col_d   = place_col;
               row_d   = place_row;
            end
         end
         S_ARMED: begin
            if (det_req && det_col == col_q && det_row == row_q) begin
               state_d = S_PENDING;
               fuse_d  = 3'd0;
            end else if (dec_en) begin
               if (fuse_q <= 3'd1) begin
                  state_d = S_PENDING;
                  fuse_d  = 3'd0;
               end else begin
                  fuse_d = fuse_q - 3'd1;
               end
            end
         end
         S_PENDING: begin
            if (report_en) state_d = S_FREE;
         end
         default: state_d = S_FREE;
      endcase
   end

   // Slot registers; coordinates are kept after expiry so the reporter can read them
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= S_FREE;
         fuse_q  <= 3'd0;
         col_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         fuse_q  <= fuse_d;
         col_q   <= col_d;
         row_q   <= row_d;
      end
   end

   assign armed    = (state_q == S_ARMED);
   assign pending  = (state_q == S_PENDING);
   assign active_d = (state_d != S_FREE);
   assign col      = col_q;
   assign row      = row_q;

endmodule

// Top: slot pool, placement arbitration and expiry reporting
module bomb_fuse_scheduler #(
   parameter int NUM_SLOTS = 4,
   parameter int FUSE_SEC  = 3,
   parameter int COORD_W   = 4
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 tick,
   input  logic                 pause,
   input  logic                 place_req,
   input  logic [COORD_W-1:0]   place_col,
   input  logic [COORD_W-1:0]   place_row,
   input  logic                 det_req,
   input  logic [COORD_W-1:0]   det_col,
   input  logic [COORD_W-1:0]   det_row,
   output logic                 place_ack,
   output logic                 place_nack,
   output logic [2:0]           place_slot,
   output logic                 explode_valid,
   output logic [2:0]           explode_slot,
   output logic [COORD_W-1:0]   explode_col,
   output logic [COORD_W-1:0]   explode_row,
   output logic [NUM_SLOTS-1:0] active_mask
);

   logic [NUM_SLOTS-1:0]              slot_armed;
   logic [NUM_SLOTS-1:0]              slot_pending;
   logic [NUM_SLOTS-1:0]              slot_active_d;
   logic [NUM_SLOTS-1:0][COORD_W-1:0] slot_col;
   logic [NUM_SLOTS-1:0][COORD_W-1:0] slot_row;
   logic [NUM_SLOTS-1:0]              grant;
   logic [NUM_SLOTS-1:0]              report;

   logic               dup, have_free, have_pend, place_ok;
   logic [2:0]         free_idx, pend_idx;
   logic [COORD_W-1:0] pend_col, pend_row;
   logic               dec_en;

   logic                 place_ack_q, place_ack_d;
   logic                 place_nack_q, place_nack_d;
   logic [2:0]           place_slot_q, place_slot_d;
   logic                 explode_valid_q, explode_valid_d;
   logic [2:0]           explode_slot_q, explode_slot_d;
   logic [COORD_W-1:0]   explode_col_q, explode_col_d;
   logic [COORD_W-1:0]   explode_row_q, explode_row_d;
   logic [NUM_SLOTS-1:0] active_mask_q, active_mask_d;

   assign dec_en = tick && !pause;

   genvar g;
   generate
      for (g = 0; g < NUM_SLOTS; g++) begin : g_slot
         bomb_fuse_slot #(
            .FUSE_SEC (FUSE_SEC),
            .COORD_W  (COORD_W)
         ) u_slot (
            .clk       (clk),
            .resetN    (resetN),
            .place_en  (grant[g]),
            .place_col (place_col),
            .place_row (place_row),
            .dec_en    (dec_en),
            .det_req   (det_req),
            .det_col   (det_col),
            .det_row   (det_row),
            .report_en (report[g]),
            .armed     (slot_armed[g]),
            .pending   (slot_pending[g]),
            .active_d  (slot_active_d[g]),
            .col       (slot_col[g]),
            .row       (slot_row[g])
         );
      end
   endgenerate

   // Arbitration on pre-edge slot state: duplicate-cell check, lowest free
   // slot for placement, lowest pending slot for reporting. A pending slot is
   // neither free nor reusable until the edge after it is reported.
   always_comb begin
      dup       = 1'b0;
      have_free = 1'b0;
      free_idx  = 3'd0;
      have_pend = 1'b0;
      pend_idx  = 3'd0;
      pend_col  = '0;
      pend_row  = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if ((slot_armed[i] || slot_pending[i]) &&
             slot_col[i] == place_col && slot_row[i] == place_row)
            dup = 1'b1;
         if (!slot_armed[i] && !slot_pending[i]) begin
            have_free = 1'b1;
            free_idx  = 3'(i);
         end
         if (slot_pending[i]) begin
            have_pend = 1'b1;
            pend_idx  = 3'(i);
            pend_col  = slot_col[i];
            pend_row  = slot_row[i];
         end
      end
      place_ok = place_req && !dup && have_free;
      grant    = '0;
      report   = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         grant[i]  = place_ok && (free_idx == 3'(i));
         report[i] = have_pend && (pend_idx == 3'(i));
      end
   end

   // Output next-state; slot and coordinate fields hold when not valid
   always_comb begin
      place_ack_d     = place_ok;
      place_nack_d    = place_req && !place_ok;
      place_slot_d    = place_ok ? free_idx : place_slot_q;
      explode_valid_d = have_pend;
      explode_slot_d  = have_pend ? pend_idx : explode_slot_q;
      explode_col_d   = have_pend ? pend_col : explode_col_q;
      explode_row_d   = have_pend ? pend_row : explode_row_q;
      active_mask_d   = slot_active_d;
   end

   // Registered outputs
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         place_ack_q     <= 1'b0;
         place_nack_q    <= 1'b0;
         place_slot_q    <= 3'd0;
         explode_valid_q <= 1'b0;
         explode_slot_q  <= 3'd0;
         explode_col_q   <= '0;
         explode_row_q   <= '0;
         active_mask_q   <= '0;
      end else begin
         place_ack_q     <= place_ack_d;
         place_nack_q    <= place_nack_d;
         place_slot_q    <= place_slot_d;
         explode_valid_q <= explode_valid_d;
         explode_slot_q  <= explode_slot_d;
         explode_col_q   <= explode_col_d;
         explode_row_q   <= explode_row_d;
         active_mask_q   <= active_mask_d;
      end
   end

   assign place_ack     = place_ack_q;
   assign place_nack    = place_nack_q;
   assign place_slot    = place_slot_q;
   assign explode_valid = explode_valid_q;
   assign explode_slot  = explode_slot_q;
   assign explode_col   = explode_col_q;
   assign explode_row   = explode_row_q;
   assign active_mask   = active_mask_q;

endmodule

// File: tb/tb_bomb_fuse_scheduler.sv
// Directed bench for bomb_fuse_scheduler with default parameters
// (4 slots, 3-tick fuse, 4-bit coordinates).
module tb_bomb_fuse_scheduler;

   logic       clk = 1'b0;
   logic       resetN;
   logic       tick, pause;
   logic       place_req;
   logic [3:0] place_col, place_row;
   logic       det_req;
   logic [3:0] det_col, det_row;
   logic       place_ack, place_nack;
   logic [2:0] place_slot;
   logic       explode_valid;
   logic [2:0] explode_slot;
   logic [3:0] explode_col, explode_row;
   logic [3:0] active_mask;

   int n_tests = 0;
   int n_fail  = 0;
   int n_expl  = 0;

   bomb_fuse_scheduler #(.NUM_SLOTS(4), .FUSE_SEC(3), .COORD_W(4)) dut (
      .clk           (clk),
      .resetN        (resetN),
      .tick          (tick),
      .pause         (pause),
      .place_req     (place_req),
      .place_col     (place_col),
      .place_row     (place_row),
      .det_req       (det_req),
      .det_col       (det_col),
      .det_row       (det_row),
      .place_ack     (place_ack),
      .place_nack    (place_nack),
      .place_slot    (place_slot),
      .explode_valid (explode_valid),
      .explode_slot  (explode_slot),
      .explode_col   (explode_col),
      .explode_row   (explode_row),
      .active_mask   (active_mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; sample 1ns after the rising edge and count explode pulses
   task automatic cycle();
      @(posedge clk);
      #1;
      if (explode_valid === 1'b1) n_expl++;
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      cycle();
      tick = 1'b0;
   endtask

   task automatic place(input logic [3:0] c, input logic [3:0] r);
      place_req = 1'b1;
      place_col = c;
      place_row = r;
      cycle();
      place_req = 1'b0;
   endtask

   initial begin
      resetN = 1'b0; tick = 0; pause = 0;
      place_req = 0; place_col = 0; place_row = 0;
      det_req = 0; det_col = 0; det_row = 0;
      cycle(); cycle();
      chk("rst_ack",    32'(place_ack), 0);
      chk("rst_nack",   32'(place_nack), 0);
      chk("rst_slot",   32'(place_slot), 0);
      chk("rst_valid",  32'(explode_valid), 0);
      chk("rst_ecol",   32'(explode_col), 0);
      chk("rst_mask",   32'(active_mask), 0);
      resetN = 1'b1;
      cycle();

      // Single bomb: place, 3 ticks, report two cycles after last tick
      place(4'd2, 4'd3);
      chk("p1_ack",  32'(place_ack), 1);
      chk("p1_slot", 32'(place_slot), 0);
      chk("p1_nack", 32'(place_nack), 0);
      chk("p1_mask", 32'(active_mask), 32'h1);
      cycle();
      chk("p1_ack_pulse", 32'(place_ack), 0);
      pulse_tick(); pulse_tick(); pulse_tick();
      chk("t1_pend_valid", 32'(explode_valid), 0);
      chk("t1_pend_mask",  32'(active_mask), 32'h1);
      cycle();
      chk("t1_valid", 32'(explode_valid), 1);
      chk("t1_slot",  32'(explode_slot), 0);
      chk("t1_col",   32'(explode_col), 2);
      chk("t1_row",   32'(explode_row), 3);
      chk("t1_mask",  32'(active_mask), 0);
      cycle();
      chk("t1_valid_pulse", 32'(explode_valid), 0);
      chk("t1_col_hold",    32'(explode_col), 2);

      // Fill pool, duplicate cell and full-pool refusals
      place(4'd1, 4'd1);
      chk("f0_slot", 32'(place_slot), 0);
      place(4'd2, 4'd3);
      chk("f1_ack",  32'(place_ack), 1);
      chk("f1_slot", 32'(place_slot), 1);
      place(4'd2, 4'd3);
      chk("dup_nack", 32'(place_nack), 1);
      chk("dup_ack",  32'(place_ack), 0);
      chk("dup_slot_hold", 32'(place_slot), 1);
      place(4'd3, 4'd3);
      chk("f2_slot", 32'(place_slot), 2);
      place(4'd4, 4'd4);
      chk("f3_slot", 32'(place_slot), 3);
      chk("full_mask", 32'(active_mask), 32'hF);
      place(4'd7, 4'd7);
      chk("full_nack", 32'(place_nack), 1);

      // All four expire together; reported 0..3 on consecutive cycles
      pulse_tick(); pulse_tick(); pulse_tick();
      chk("all_pend_mask", 32'(active_mask), 32'hF);
      // Cell (1,1) is still occupied while its slot reports
      place(4'd1, 4'd1);
      chk("rA_nack",  32'(place_nack), 1);
      chk("rA_valid", 32'(explode_valid), 1);
      chk("rA_slot",  32'(explode_slot), 0);
      chk("rA_mask",  32'(active_mask), 32'hE);
      // Slot 0 freed on the previous edge: reusable now
      place(4'd5, 4'd6);
      chk("rB_ack",   32'(place_ack), 1);
      chk("rB_slot",  32'(place_slot), 0);
      chk("rB_eslot", 32'(explode_slot), 1);
      chk("rB_ecol",  32'(explode_col), 2);
      chk("rB_erow",  32'(explode_row), 3);
      chk("rB_mask",  32'(active_mask), 32'hD);
      cycle();
      chk("rC_eslot", 32'(explode_slot), 2);
      chk("rC_mask",  32'(active_mask), 32'h9);
      cycle();
      chk("rD_eslot", 32'(explode_slot), 3);
      chk("rD_ecol",  32'(explode_col), 4);
      chk("rD_mask",  32'(active_mask), 32'h1);
      cycle();
      chk("rE_valid", 32'(explode_valid), 0);

      // Chain-reaction hit with fuse 2 remaining
      pulse_tick();
      det_req = 1'b1; det_col = 4'd5; det_row = 4'd6;
      cycle();
      det_req = 1'b0;
      chk("det_pend_valid", 32'(explode_valid), 0);
      chk("det_pend_mask",  32'(active_mask), 32'h1);
      cycle();
      chk("det_valid", 32'(explode_valid), 1);
      chk("det_slot",  32'(explode_slot), 0);
      chk("det_col",   32'(explode_col), 5);
      chk("det_row",   32'(explode_row), 6);
      chk("det_mask",  32'(active_mask), 0);
      // Hit on an empty cell does nothing
      det_req = 1'b1; det_col = 4'd9; det_row = 4'd9;
      n_expl = 0;
      cycle();
      det_req = 1'b0;
      cycle(); cycle();
      chk("det_empty_expl", 32'(n_expl), 0);
      chk("det_empty_mask", 32'(active_mask), 0);

      // Pause freezes fuses only
      place(4'd2, 4'd3);
      chk("pz_slot", 32'(place_slot), 0);
      pause = 1'b1;
      n_expl = 0;
      for (int k = 0; k < 10; k++) pulse_tick();
      cycle(); cycle();
      chk("pz_expl", 32'(n_expl), 0);
      chk("pz_mask", 32'(active_mask), 32'h1);
      place(4'd7, 4'd7);
      chk("pz_place_slot", 32'(place_slot), 1);
      det_req = 1'b1; det_col = 4'd7; det_row = 4'd7;
      cycle();
      det_req = 1'b0;
      cycle();
      chk("pz_det_valid", 32'(explode_valid), 1);
      chk("pz_det_slot",  32'(explode_slot), 1);
      chk("pz_det_col",   32'(explode_col), 7);
      chk("pz_det_mask",  32'(active_mask), 32'h1);
      pause = 1'b0;
      cycle();
      pulse_tick(); pulse_tick(); pulse_tick();
      cycle();
      chk("pz_end_valid", 32'(explode_valid), 1);
      chk("pz_end_slot",  32'(explode_slot), 0);
      chk("pz_end_row",   32'(explode_row), 3);
      chk("pz_end_mask",  32'(active_mask), 0);
      cycle();

      // Reset mid-countdown discards bombs silently
      place(4'd1, 4'd2);
      place(4'd3, 4'd4);
      chk("mr_slot", 32'(place_slot), 1);
      pulse_tick(); pulse_tick();
      resetN = 1'b0;
      #1;
      chk("mr_mask",  32'(active_mask), 0);
      chk("mr_ack",   32'(place_ack), 0);
      chk("mr_slot0", 32'(place_slot), 0);
      chk("mr_valid", 32'(explode_valid), 0);
      chk("mr_ecol",  32'(explode_col), 0);
      cycle(); cycle();
      resetN = 1'b1;
      n_expl = 0;
      pulse_tick(); pulse_tick(); pulse_tick();
      cycle(); cycle(); cycle();
      chk("mr_expl", 32'(n_expl), 0);
      chk("mr_mask_after", 32'(active_mask), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
